// File: rtl/ethpipe_rx_slot_ctrl.sv
// RX frame slot ring scheduler: arms the GMII receiver, records frame descriptors, hands slots to the host.
// Optional ETHPIPE_RX_STATS_EN adds frame/byte/stall counters.
module ethpipe_rx_slot_ctrl #(
  parameter int SLOT_BITS = 2,
  parameter int LEN_W     = 12,
  parameter int MIN_GAP   = 4
) (
  input  logic                 pci_clk,
  input  logic                 sys_rst,
  input  logic                 rx_complete,
  input  logic [LEN_W-1:0]     rx_frame_len,
  input  logic [63:0]          rx_timestamp,
  output logic                 rx_empty,
  output logic [SLOT_BITS-1:0] rx_wr_slot,
  output logic                 host_valid,
  output logic [SLOT_BITS-1:0] host_rd_slot,
  output logic [LEN_W-1:0]     host_frame_len,
  output logic [63:0]          host_timestamp,
  input  logic                 host_release,
  output logic [SLOT_BITS:0]   slot_count,
`ifdef ETHPIPE_RX_STATS_EN
  output logic [31:0]          stat_frames,
  output logic [47:0]          stat_bytes,
  output logic [31:0]          stat_stall,
`endif
  output logic                 proto_err
);

  localparam int SLOTS = 1 << SLOT_BITS;
  localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [SLOT_BITS:0] FULL = (SLOT_BITS + 1)'(SLOTS);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    GAP,
    ARMED,
    COMMIT,
    WAIT_FREE
  } state_t;

  state_t               state;
  logic [GW-1:0]        gap_cnt;
  logic [SLOT_BITS-1:0] wr_ptr;
  logic [SLOT_BITS-1:0] rd_ptr;
  logic [LEN_W-1:0]     hold_len;
  logic [63:0]          hold_ts;
  logic [LEN_W-1:0]     desc_len [SLOTS];
  logic [63:0]          desc_ts  [SLOTS];

  logic                 commit;
  logic                 release_ok;
  logic [SLOT_BITS:0]   count_next;
  logic                 has_room;

  assign rx_wr_slot     = wr_ptr;
  assign host_rd_slot   = rd_ptr;
  assign host_frame_len = desc_len[rd_ptr];
  assign host_timestamp = desc_ts[rd_ptr];
  assign host_valid     = (slot_count != '0);

  // Room is judged on the post-release count so a free slot re-arms at once.
  always_comb begin
    commit     = (state == COMMIT);
    release_ok = host_release && (slot_count != '0);
    count_next = slot_count;
    if (commit && !release_ok)
      count_next = slot_count + (SLOT_BITS + 1)'(1);
    else if (!commit && release_ok)
      count_next = slot_count - (SLOT_BITS + 1)'(1);
    has_room = (count_next < FULL);
  end

  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= GAP;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      slot_count <= '0;
      hold_len   <= '0;
      hold_ts    <= '0;
      rx_empty   <= 1'b0;
      proto_err  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        desc_len[i] <= '0;
        desc_ts[i]  <= '0;
      end
`ifdef ETHPIPE_RX_STATS_EN
      stat_frames <= '0;
      stat_bytes  <= '0;
      stat_stall  <= '0;
`endif
    end else begin
      if (host_release && (slot_count == '0))
        proto_err <= 1'b1;
      if (rx_complete && (state != ARMED))
        proto_err <= 1'b1;

      slot_count <= count_next;
      if (release_ok)
        rd_ptr <= rd_ptr + SLOT_BITS'(1);

      unique case (state)
        ARMED: begin
          if (rx_complete) begin
            hold_len <= rx_frame_len;
            hold_ts  <= rx_timestamp;
            rx_empty <= 1'b0;
            state    <= COMMIT;
          end
        end
        COMMIT: begin
          desc_len[wr_ptr] <= hold_len;
          desc_ts[wr_ptr]  <= hold_ts;
          wr_ptr  <= wr_ptr + SLOT_BITS'(1);
          gap_cnt <= '0;
          state   <= GAP;
`ifdef ETHPIPE_RX_STATS_EN
          stat_frames <= stat_frames + 32'd1;
          stat_bytes  <= stat_bytes + 48'(hold_len);
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (has_room) begin
              rx_empty <= 1'b1;
              state    <= ARMED;
            end else begin
              state <= WAIT_FREE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        WAIT_FREE: begin
`ifdef ETHPIPE_RX_STATS_EN
          stat_stall <= stat_stall + 32'd1;
`endif
          if (has_room) begin
            rx_empty <= 1'b1;
            state    <= ARMED;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_ethpipe_rx_slot_ctrl.sv
// Bench for ethpipe_rx_slot_ctrl: descriptor scoreboard, wrap table, corner sequences.
module tb_ethpipe_rx_slot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_complete = 1'b0;
  logic [11:0] len = '0;
  logic [63:0] ts = '0;
  logic        host_release = 1'b0;
  logic        rx_empty;
  logic [1:0]  rx_wr_slot;
  logic        host_valid;
  logic [1:0]  host_rd_slot;
  logic [11:0] host_frame_len;
  logic [63:0] host_timestamp;
  logic [2:0]  slot_count;
  logic        proto_err;
`ifdef ETHPIPE_RX_STATS_EN
  logic [31:0] stat_frames;
  logic [47:0] stat_bytes;
  logic [31:0] stat_stall;
`endif

  ethpipe_rx_slot_ctrl dut (
    .pci_clk        (clk),
    .sys_rst        (rst),
    .rx_complete    (rx_complete),
    .rx_frame_len   (len),
    .rx_timestamp   (ts),
    .rx_empty       (rx_empty),
    .rx_wr_slot     (rx_wr_slot),
    .host_valid     (host_valid),
    .host_rd_slot   (host_rd_slot),
    .host_frame_len (host_frame_len),
    .host_timestamp (host_timestamp),
    .host_release   (host_release),
    .slot_count     (slot_count),
`ifdef ETHPIPE_RX_STATS_EN
    .stat_frames    (stat_frames),
    .stat_bytes     (stat_bytes),
    .stat_stall     (stat_stall),
`endif
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] len;
    logic [63:0] ts;
  } desc_t;

  typedef struct {
    logic [11:0] len;
    logic [63:0] ts;
    logic [1:0]  exp_slot;
  } vec_t;

  desc_t sb[$];
  vec_t  vecs[10];
  int    checks = 0;
  int    errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_complete = 1'b0;
    host_release = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic startup_gap(input string n);
    chk({n, "_empty0"}, rx_empty, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("%s_empty%0d", n, i), rx_empty, (i == 4));
    end
  endtask

  task automatic wait_armed(input string n);
    int k = 0;
    while (!rx_empty && k < 40) begin
      tick();
      k++;
    end
    chk({n, "_armed"}, rx_empty, 1'b1);
  endtask

  task automatic send(input logic [11:0] l, input logic [63:0] t);
    desc_t d;
    len = l;
    ts = t;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    d.len = l;
    d.ts = t;
    sb.push_back(d);
  endtask

  task automatic cmp_front(input string n);
    desc_t d;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, host_valid %0b", n, host_valid);
    end else begin
      d = sb[0];
      chk({n, "_len"}, host_frame_len, d.len);
      chk({n, "_ts"}, host_timestamp, d.ts);
    end
  endtask

  task automatic release_front(input string n);
    chk({n, "_valid"}, host_valid, 1'b1);
    cmp_front(n);
    if (sb.size() != 0) void'(sb.pop_front());
    host_release = 1'b1;
    tick();
    host_release = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      vecs[i].len = 12'(100 + 37 * i);
      vecs[i].ts = 64'hCAFE_0000_0000_0000 + 64'(i * 3);
      vecs[i].exp_slot = 2'((1 + i) % 4);
    end

    // 1: reset and idle arm
    do_reset();
    chk("rst_wr_slot", rx_wr_slot, 0);
    chk("rst_rd_slot", host_rd_slot, 0);
    chk("rst_valid", host_valid, 0);
    chk("rst_count", slot_count, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_len", host_frame_len, 0);
    chk("rst_ts", host_timestamp, 0);
    startup_gap("t1");

    // 2: single frame
    send(12'd64, 64'h1234);
    chk("t2_count_early", slot_count, 0);
    tick();
    chk("t2_valid", host_valid, 1);
    chk("t2_rd_slot", host_rd_slot, 0);
    chk("t2_wr_slot", rx_wr_slot, 1);
    chk("t2_count", slot_count, 1);
    cmp_front("t2");
    for (int i = 0; i < 3; i++) tick();
    chk("t2_empty_c5", rx_empty, 0);
    tick();
    chk("t2_empty_c6", rx_empty, 1);
    release_front("t2_rel");
    chk("t2_count_after", slot_count, 0);
    chk("t2_rd_after", host_rd_slot, 1);

    // 3: fill the ring
    for (int i = 0; i < 4; i++) begin
      wait_armed($sformatf("t3_f%0d", i));
      send(12'(60 + i), 64'h5000 + 64'(i));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_full_empty%0d", i), rx_empty, 0);
    end
    chk("t3_count", slot_count, 4);
    chk("t3_first_len", host_frame_len, 60);
    release_front("t3_rel0");
    chk("t3_rearm", rx_empty, 1);
    chk("t3_next_len", host_frame_len, 61);
    chk("t3_count3", slot_count, 3);
    for (int i = 1; i < 4; i++)
      release_front($sformatf("t3_rel%0d", i));
    chk("t3_drained", slot_count, 0);

    // 4: wrap-around table
    for (int i = 0; i < 10; i++) begin
      wait_armed($sformatf("t4_%0d", i));
      send(vecs[i].len, vecs[i].ts);
      tick();
      chk($sformatf("t4_%0d_count", i), slot_count, 1);
      chk($sformatf("t4_%0d_slot", i), host_rd_slot, vecs[i].exp_slot);
      chk($sformatf("t4_%0d_tlen", i), host_frame_len, vecs[i].len);
      release_front($sformatf("t4_%0d", i));
      chk($sformatf("t4_%0d_count0", i), slot_count, 0);
    end
    chk("t4_perr", proto_err, 0);

    // 5: release coincides with COMMIT
    wait_armed("t5_a");
    send(12'd300, 64'hA);
    wait_armed("t5_b");
    send(12'd301, 64'hB);
    wait_armed("t5_c");
    chk("t5_count_pre", slot_count, 2);
    chk("t5_rd_pre", host_rd_slot, 3);
    chk("t5_wr_pre", rx_wr_slot, 1);
    cmp_front("t5_a");
    send(12'd302, 64'hC);
    void'(sb.pop_front());
    host_release = 1'b1;
    tick();
    host_release = 1'b0;
    chk("t5_count", slot_count, 2);
    chk("t5_rd", host_rd_slot, 0);
    chk("t5_wr", rx_wr_slot, 2);
    release_front("t5_b");
    release_front("t5_c");
    chk("t5_perr", proto_err, 0);

    // 6a: rx_complete during GAP is dropped
    wait_armed("t6a");
    send(12'd100, 64'hAAAA);
    tick();
    len = 12'd999;
    ts = 64'hDEAD;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    tick();
    tick();
    chk("t6a_count", slot_count, 1);
    chk("t6a_perr", proto_err, 1);
    chk("t6a_wr", rx_wr_slot, 3);
    cmp_front("t6a");

    // 6b: release while empty
    do_reset();
    chk("t6b_perr_clr", proto_err, 0);
    host_release = 1'b1;
    tick();
    host_release = 1'b0;
    chk("t6b_perr", proto_err, 1);
    chk("t6b_rd", host_rd_slot, 0);
    chk("t6b_count", slot_count, 0);

    // 6c: async reset mid-GAP
    wait_armed("t6c");
    send(12'd77, 64'h77);
    tick();
    tick();
    chk("t6c_pre_count", slot_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6c_count", slot_count, 0);
    chk("t6c_valid", host_valid, 0);
    chk("t6c_wr", rx_wr_slot, 0);
    chk("t6c_rd", host_rd_slot, 0);
    chk("t6c_perr", proto_err, 0);
    chk("t6c_empty", rx_empty, 0);
    chk("t6c_len", host_frame_len, 0);
    chk("t6c_ts", host_timestamp, 0);
    tick();
    rst = 1'b0;
    sb.delete();
    startup_gap("t6c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ethpipe_rx_slot_ctrl.md
Name: ethpipe_rx_slot_ctrl

Overview:
PCI-clock-domain scheduler for the RX frame slot ring between the GMII receiver and the host.
- Selects which slot the receiver fills next.
- Generates the per-frame `rx_empty` arm pulse the receiver synchronises.
- Latches each completed frame's length and timestamp into a per-slot descriptor.
- Presents the oldest filled slot to the host and frees it on a release strobe.

Parameters:
SLOT_BITS, 2, log2 of slot count (4 slots); ring pointers are SLOT_BITS wide.
LEN_W, 12, frame length width.
MIN_GAP, 4, pci_clk cycles `rx_empty` stays low between frames (≥2 so the receiver's synchroniser sees the edge).

Ports:
pci_clk  in  1  sole clock
sys_rst  in  1  asynchronous, active-high reset
rx_complete  in  1  one-cycle pulse (already synchronised to pci_clk): current write slot holds a frame
rx_frame_len  in  LEN_W  length of completed frame, stable when rx_complete=1
rx_timestamp  in  64  timestamp of completed frame, stable when rx_complete=1
rx_empty  out  1  write slot free and armed; receiver may accept a frame
rx_wr_slot  out  SLOT_BITS  slot index the receiver writes (upper slot address bits)
host_valid  out  1  at least one filled slot pending
host_rd_slot  out  SLOT_BITS  oldest filled slot index
host_frame_len  out  LEN_W  descriptor length of host_rd_slot
host_timestamp  out  64  descriptor timestamp of host_rd_slot
host_release  in  1  one-cycle pulse: host finished with host_rd_slot
slot_count  out  SLOT_BITS+1  number of filled slots, 0..2^SLOT_BITS
proto_err  out  1  sticky; set on protocol violation, cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0; slot_count = 0; descriptors = 0.
  - rx_empty = 0, host_valid = 0, proto_err = 0.
  - State = GAP with gap_cnt = 0.
- Outputs:
  - rx_wr_slot = wr_ptr; host_rd_slot = rd_ptr.
  - host_frame_len / host_timestamp = descriptor[rd_ptr], combinational read of register array.
  - host_valid = (slot_count != 0).
- FSM:
  - ARMED: rx_empty=1. On rx_complete → COMMIT.
  - COMMIT (1 cycle, rx_empty=0):
    - descriptor[wr_ptr] ← {rx_frame_len, rx_timestamp}, captured in the cycle rx_complete is high (registered into holding regs, written here).
    - wr_ptr ← wr_ptr+1 mod 2^SLOT_BITS; slot_count +1.
    - → GAP with gap_cnt = 0.
  - GAP: rx_empty=0, gap_cnt +1 per cycle. When gap_cnt == MIN_GAP-1:
    - → ARMED if slot_count < 2^SLOT_BITS (evaluated with this cycle's release applied);
    - else → WAIT_FREE.
  - WAIT_FREE: rx_empty=0. Leave on first cycle slot_count < 2^SLOT_BITS → ARMED.
- Latency:
  - rx_complete → slot_count incremented: 2 cycles.
  - rx_complete → rx_empty high again, ring not full: MIN_GAP+2 cycles.
- Release:
  - host_release with host_valid=1: rd_ptr +1 mod 2^SLOT_BITS, slot_count −1.
  - host_release with host_valid=0: ignored, proto_err ← 1.
- Simultaneous COMMIT write and release in the same cycle: slot_count unchanged; both pointers advance.
- rx_complete in any state other than ARMED: frame discarded, no pointer/count change, proto_err ← 1.
- Full: slot_count == 2^SLOT_BITS means no slot free; rx_empty is never 1 while full.
- Wrap-around: pointers wrap naturally. Full vs empty is distinguished by slot_count, never by pointer compare.
- Reset mid-frame: all state cleared; any pending descriptor lost; rx_empty low for MIN_GAP cycles after release.

Optional Feature:
Macro: ETHPIPE_RX_STATS_EN.
- Defined:
  - Adds outputs stat_frames (32) and stat_bytes (48), both 0 on reset, wrap on overflow.
  - Each COMMIT adds 1 to stat_frames and rx_frame_len to stat_bytes (zero-extended).
  - Adds output stat_stall (32): counts cycles spent in WAIT_FREE.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
1. Reset, then idle: rx_empty=0 for 4 cycles after sys_rst drops, then 1; rx_wr_slot=0, host_valid=0, slot_count=0.
2. Single frame, rx_complete with len=64, ts=0x1234:
   - 2 cycles later host_valid=1, host_rd_slot=0, host_frame_len=64, host_timestamp=0x1234, rx_wr_slot=1.
   - rx_empty returns high at cycle 6.
   - host_release → slot_count=0, host_rd_slot=1.
3. Fill ring, no releases, 4 frames (len 60,61,62,63): slot_count=4, state WAIT_FREE, rx_empty stays 0.
   - One host_release → rx_empty=1 next cycle; host_frame_len=61.
4. Wrap-around, 10 frames with release after each: pointers pass 3→0.
   - Each descriptor read matches its frame.
   - slot_count never exceeds 1; proto_err=0.
5. Simultaneous: with slot_count=2, host_release coincides with the COMMIT cycle → slot_count stays 2, rd_ptr and wr_ptr each advance by 1.
6. Protocol errors:
   - rx_complete during GAP → count unchanged, proto_err=1.
   - After reset, host_release with slot_count=0 → proto_err=1, rd_ptr=0.
   - Async reset asserted mid-GAP → all outputs at reset values immediately.
